arb_req_stage: RTL and testbench

ARB_REQ_STAGE -- requirements
Module: arb_req_stage

---
 rtl/arb_req_stage.sv | 150 +++++++++++++++
 tb/tb_arb_req_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_stage.sv
// rtl/arb_req_stage.sv - request staging and burst beat sequencer in front of a fixed-priority arbiter
//
// Each port parks one request (pending bit + burst length) until the external
// combinational arbiter grants it. A granted port then owns a burst of len+1
// beats. Only one burst runs at a time.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   req_valid_i    per-port request valid
//   req_len_i      per-port burst length minus one, port p at [p*LEN_W +: LEN_W]
//   req_ready_o    per-port ready (port has no request parked)
//   arb_req_o      request vector to the downstream arbiter (registered only)
//   arb_gnt_i      one-hot grant from the arbiter, same cycle
//   beat_valid_o   beat valid for the owning port
//   beat_port_o    one-hot owner of the current beat
//   beat_last_o    final beat of the burst
//   beat_ready_i   beat consumer ready
//   busy_o         burst in progress
//   err_o          sticky flag for an illegal grant

module arb_req_stage #(
    parameter int NUM_PORTS = 4,
    parameter int LEN_W     = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_PORTS-1:0]       req_valid_i,
    input  logic [NUM_PORTS*LEN_W-1:0] req_len_i,
    output logic [NUM_PORTS-1:0]       req_ready_o,
    output logic [NUM_PORTS-1:0]       arb_req_o,
    input  logic [NUM_PORTS-1:0]       arb_gnt_i,
    output logic                       beat_valid_o,
    output logic [NUM_PORTS-1:0]       beat_port_o,
    output logic                       beat_last_o,
    input  logic                       beat_ready_i,
    output logic                       busy_o,
    output logic                       err_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] owner;
    logic [LEN_W-1:0]     len_q [NUM_PORTS];
    logic [LEN_W-1:0]     cnt;
    logic [LEN_W-1:0]     gnt_len;
    logic [NUM_PORTS-1:0] accept;
    logic                 in_idle;
    logic                 gnt_nonzero;
    logic                 gnt_onehot;
    logic                 gnt_covered;
    logic                 gnt_legal;
    logic                 gnt_illegal;
    logic                 beat_fire;
    logic                 burst_done;

    assign in_idle     = (state == IDLE);
    assign accept      = req_valid_i & ~pending;

    // A grant is only trusted when it is one-hot and names a port that
    // actually has a request parked; anything else is an arbiter fault.
    assign gnt_nonzero = |arb_gnt_i;
    assign gnt_onehot  = gnt_nonzero && ((arb_gnt_i & (arb_gnt_i - NUM_PORTS'(1))) == '0);
    assign gnt_covered = ((arb_gnt_i & ~pending) == '0);
    assign gnt_legal   = in_idle && gnt_onehot && gnt_covered;
    assign gnt_illegal = in_idle && gnt_nonzero && !gnt_legal;

    assign beat_fire   = (state == BURST) && beat_ready_i;
    assign burst_done  = beat_fire && (cnt == '0);

    // Length of the granted port; the grant is one-hot when it is used.
    always_comb begin
        gnt_len = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (arb_gnt_i[p]) begin
                gnt_len = gnt_len | len_q[p];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_legal)  state_nxt = BURST;
            BURST:   if (burst_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request parking. A granted port's pending bit drops at the grant edge,
    // which reopens its ready so it can queue a follow-up during its burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                len_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt_legal && arb_gnt_i[p]) begin
                    pending[p] <= 1'b0;
                end else if (accept[p]) begin
                    pending[p] <= 1'b1;
                    len_q[p]   <= req_len_i[p*LEN_W +: LEN_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner <= '0;
            cnt   <= '0;
            err_o <= 1'b0;
        end else begin
            if (gnt_legal) begin
                owner <= arb_gnt_i;
                cnt   <= gnt_len;
            end else if (beat_fire && (cnt != '0)) begin
                cnt <= cnt - LEN_W'(1);
            end
            if (gnt_illegal) begin
                err_o <= 1'b1;
            end
        end
    end

    // All outputs come from registers only; arb_req_o never sees req_valid_i
    // directly, which keeps the arbiter loop free of combinational paths.
    assign req_ready_o  = ~pending;
    assign arb_req_o    = in_idle ? pending : '0;
    assign beat_valid_o = (state == BURST);
    assign beat_port_o  = beat_valid_o ? owner : '0;
    assign beat_last_o  = beat_valid_o && (cnt == '0);
    assign busy_o       = beat_valid_o;

endmodule

// File: tb/tb_arb_req_stage.sv
// tb/tb_arb_req_stage.sv - directed self-checking bench for arb_req_stage

module tb_arb_req_stage;

    localparam int NP = 4;
    localparam int LW = 4;

    logic          clk;
    logic          reset_n;
    logic [NP-1:0] req_valid;
    logic [NP*LW-1:0] req_len;
    logic [NP-1:0] req_ready;
    logic [NP-1:0] arb_req;
    logic [NP-1:0] arb_gnt;
    logic          beat_valid;
    logic [NP-1:0] beat_port;
    logic          beat_last;
    logic          beat_ready;
    logic          busy;
    logic          err;

    logic          force_en;
    logic [NP-1:0] force_gnt;

    int n_checks;
    int n_errors;

    arb_req_stage #(.NUM_PORTS(NP), .LEN_W(LW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (req_valid),
        .req_len_i   (req_len),
        .req_ready_o (req_ready),
        .arb_req_o   (arb_req),
        .arb_gnt_i   (arb_gnt),
        .beat_valid_o(beat_valid),
        .beat_port_o (beat_port),
        .beat_last_o (beat_last),
        .beat_ready_i(beat_ready),
        .busy_o      (busy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-priority arbiter, port 0 highest; can be overridden to inject faults.
    always_comb begin
        arb_gnt = '0;
        if (force_en) begin
            arb_gnt = force_gnt;
        end else begin
            for (int i = NP - 1; i >= 0; i--) begin
                if (arb_req[i]) arb_gnt = NP'(1) << i;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [NP-1:0] exp_req);
        check({tag, " beat_valid"}, 32'(beat_valid), 32'd0);
        check({tag, " busy"},       32'(busy),       32'd0);
        check({tag, " beat_port"},  32'(beat_port),  32'd0);
        check({tag, " arb_req"},    32'(arb_req),    32'(exp_req));
    endtask

    task automatic check_beat(input string tag, input logic [NP-1:0] port, input logic last);
        check({tag, " beat_valid"}, 32'(beat_valid), 32'd1);
        check({tag, " busy"},       32'(busy),       32'd1);
        check({tag, " beat_port"},  32'(beat_port),  32'(port));
        check({tag, " beat_last"},  32'(beat_last),  32'(last));
        check({tag, " arb_req"},    32'(arb_req),    32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        req_valid  = '0;
        req_len    = '0;
        beat_ready = 1'b1;
        force_en   = 1'b0;
        force_gnt  = '0;

        // Reset state
        #2;
        check("rst req_ready", 32'(req_ready), 32'hF);
        check("rst err",       32'(err),       32'd0);
        check("rst beat_last", 32'(beat_last), 32'd0);
        check_idle("rst", 4'b0000);
        step();
        reset_n = 1'b1;
        step();

        // Single port 2, len=3: four beats, last on the fourth
        req_valid = 4'b0100;
        req_len   = 16'h0300;
        step();
        check("s1 arb_req",   32'(arb_req),   32'h4);
        check("s1 req_ready", 32'(req_ready), 32'hB);
        check("s1 idle",      32'(beat_valid), 32'd0);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_beat("s1 beat", 4'b0100, (i == 3));
        end
        check("s1 ready in burst", 32'(req_ready), 32'hF);
        step();
        check_idle("s1 end", 4'b0000);

        // Ports 0 and 3 together, len=0: port 0, one idle cycle, port 3
        req_valid = 4'b1001;
        req_len   = 16'h0000;
        step();
        check("s2 arb_req", 32'(arb_req), 32'h9);
        req_valid = '0;
        step();
        check_beat("s2 p0", 4'b0001, 1'b1);
        step();
        check_idle("s2 gap", 4'b1000);
        step();
        check_beat("s2 p3", 4'b1000, 1'b1);
        step();
        check_idle("s2 end", 4'b0000);

        // Port 1 len=3 with a three-cycle consumer stall on the second beat
        req_valid = 4'b0010;
        req_len   = 16'h0030;
        step();
        req_valid = '0;
        step();
        check_beat("s3 b1", 4'b0010, 1'b0);
        step();
        check_beat("s3 b2", 4'b0010, 1'b0);
        beat_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_beat("s3 stall", 4'b0010, 1'b0);
        end
        beat_ready = 1'b1;
        step();
        check_beat("s3 b3", 4'b0010, 1'b0);
        step();
        check_beat("s3 b4", 4'b0010, 1'b1);
        step();
        check_idle("s3 end", 4'b0000);

        // Illegal grant: two bits set
        force_en  = 1'b1;
        force_gnt = 4'b0000;
        req_valid = 4'b0001;
        req_len   = 16'h0000;
        step();
        req_valid = '0;
        check("s4 zero gnt err", 32'(err), 32'd0);
        check_idle("s4 parked", 4'b0001);
        force_gnt = 4'b0011;
        step();
        check("s4 multi err", 32'(err), 32'd1);
        check_idle("s4 multi", 4'b0001);
        force_gnt = 4'b0000;
        step();
        check("s4 sticky", 32'(err), 32'd1);
        do_reset();
        check("s4 err cleared", 32'(err), 32'd0);

        // Illegal grant: names a port with nothing parked
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        force_gnt = 4'b1000;
        step();
        check("s4 uncovered err", 32'(err), 32'd1);
        check_idle("s4 uncovered", 4'b0001);
        force_en = 1'b0;
        step();
        check_beat("s4 recover", 4'b0001, 1'b1);
        check("s4 err held", 32'(err), 32'd1);
        step();
        do_reset();
        step();

        // Port 1 re-requests during its own len=2 burst
        req_valid = 4'b0010;
        req_len   = 16'h0020;
        step();
        check("s5 blocked", 32'(req_ready), 32'hD);
        step();
        check_beat("s5 b1", 4'b0010, 1'b0);
        check("s5 ready after gnt", 32'(req_ready), 32'hF);
        step();
        check_beat("s5 b2", 4'b0010, 1'b0);
        check("s5 reaccepted", 32'(req_ready), 32'hD);
        req_valid = '0;
        step();
        check_beat("s5 b3", 4'b0010, 1'b1);
        step();
        check_idle("s5 gap", 4'b0010);
        step();
        check_beat("s5 r1", 4'b0010, 1'b0);
        step();
        check_beat("s5 r2", 4'b0010, 1'b0);
        step();
        check_beat("s5 r3", 4'b0010, 1'b1);
        step();
        check_idle("s5 end", 4'b0000);

        // Reset on the second beat of a len=7 burst, port 2 still parked
        req_valid = 4'b0101;
        req_len   = 16'h0707;
        step();
        req_valid = '0;
        step();
        check_beat("s6 b1", 4'b0001, 1'b0);
        step();
        check_beat("s6 b2", 4'b0001, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("s6 async req_ready", 32'(req_ready), 32'hF);
        check_idle("s6 async", 4'b0000);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("s6 after", 4'b0000);
        end
        check("s6 err", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
